// File: rtl/multicycle_processor_if.sv
// Run/done handshake and data bus of the multicycle processor.
// Optional macro PROC_FLAGS_EN adds the zero/carry flag outputs.
interface multicycle_processor_if #(
  parameter int unsigned DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] iin;
  logic              done;
  logic [DATA_W-1:0] outputProcessor;
`ifdef PROC_FLAGS_EN
  logic              zero;
  logic              carry;

  modport master (output run, iin, input done, outputProcessor, zero, carry);
  modport slave  (input run, iin, output done, outputProcessor, zero, carry);
`else
  modport master (output run, iin, input done, outputProcessor);
  modport slave  (input run, iin, output done, outputProcessor);
`endif
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle processor core: 9-bit instruction field, eight DATA_W registers, 2 or 4 steps.
// Optional macro PROC_FLAGS_EN adds zero/carry flags and the mvnz instruction (opcode 110).
module multicycle_processor #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  multicycle_processor_if.slave  bus
);
  localparam int unsigned IR_W = 9;
  localparam int unsigned NREG = 8;
`ifdef PROC_FLAGS_EN
  localparam int unsigned ALU_W = DATA_W + 1;
`else
  localparam int unsigned ALU_W = DATA_W;
`endif

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  step_t             step;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] r [NREG];
  logic              done_q;
  logic [DATA_W-1:0] out_q;
`ifdef PROC_FLAGS_EN
  logic              zero_q;
  logic              carry_q;
`endif

  logic [2:0]        op_c;
  logic [2:0]        x_c;
  logic [2:0]        y_c;
  logic [DATA_W-1:0] rx_c;
  logic [DATA_W-1:0] ry_c;
  logic [ALU_W-1:0]  alu_c;

  assign op_c = ir[8:6];
  assign x_c  = ir[5:3];
  assign y_c  = ir[2:0];
  assign rx_c = r[x_c];
  assign ry_c = r[y_c];

  // ALU; in the flags build the extra top bit is the carry (add) or borrow (sub)
  always_comb begin
    alu_c = '0;
    case (op_c)
      OP_ADD:  alu_c = ALU_W'(a) + ALU_W'(ry_c);
      OP_SUB:  alu_c = ALU_W'(a) - ALU_W'(ry_c);
      OP_AND:  alu_c = ALU_W'(a & ry_c);
      OP_OR:   alu_c = ALU_W'(a | ry_c);
      default: alu_c = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step    <= T0;
      ir      <= '0;
      a       <= '0;
      g       <= '0;
      r       <= '{default: '0};
      done_q  <= 1'b0;
      out_q   <= '0;
`ifdef PROC_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (step)
        T0: begin
          if (bus.run) begin
            ir   <= bus.iin[DATA_W-1 -: IR_W];
            step <= T1;
          end
        end
        T1: begin
          step   <= T0;
          done_q <= 1'b1;
          case (op_c)
            OP_MV: begin
              r[x_c] <= ry_c;
              out_q  <= ry_c;
            end
            OP_MVI: begin
              r[x_c] <= bus.iin;
              out_q  <= bus.iin;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              a      <= rx_c;
              step   <= T2;
              done_q <= 1'b0;
            end
`ifdef PROC_FLAGS_EN
            OP_MVNZ: begin
              if (!zero_q) begin
                r[x_c] <= ry_c;
                out_q  <= ry_c;
              end
            end
`endif
            default: ;
          endcase
        end
        T2: begin
          g    <= alu_c[DATA_W-1:0];
          step <= T3;
`ifdef PROC_FLAGS_EN
          zero_q  <= (alu_c[DATA_W-1:0] == '0);
          carry_q <= alu_c[ALU_W-1];
`endif
        end
        T3: begin
          r[x_c] <= g;
          out_q  <= g;
          done_q <= 1'b1;
          step   <= T0;
        end
        default: step <= T0;
      endcase
    end
  end

  assign bus.done            = done_q;
  assign bus.outputProcessor = out_q;
`ifdef PROC_FLAGS_EN
  assign bus.zero            = zero_q;
  assign bus.carry           = carry_q;
`endif
endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multi-cycle processor core: fetches a 9-bit instruction field from the instruction/data input bus and executes it in 2 or 4 clock steps over eight DATA_W-bit general registers. Successor of the original fixed 16-bit step-counter processor: adds configurable data width, a run/done handshake, a real ALU path (add/sub/and/or) and an optional flags/conditional-move extension. Sits at the top of the datapath, fed by the instruction memory or switches and driving the display/bus output.

## Interface
- DATA_W, 16, datapath and register width; legal range 9..32; the instruction field is always the top 9 bits of iin.
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  start request; sampled only in step T0.
- iin  in  DATA_W  instruction word in T0; immediate data word in T1 of mvi.
- done  out  1  registered one-cycle pulse; the instruction completed at the preceding edge.
- outputProcessor  out  DATA_W  registered copy of the last value written to any register.
- zero  out  1  (PROC_FLAGS_EN only) result of the last ALU op was 0.
- carry  out  1  (PROC_FLAGS_EN only) carry/borrow of the last add/sub.

## Operation
- IR = {III, XXX, YYY} = iin[DATA_W-1 -: 9]; Rx = R[XXX], Ry = R[YYY].
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←iin; 010 add Rx←Rx+Ry; 011 sub Rx←Rx−Ry; 100 and; 101 or; 110 mvnz (flags build) or NOP; 111 NOP.
- Step counter (2-bit) states: T0 idle/fetch, T1, T2, T3. Internal registers: IR (9b), A (DATA_W), G (DATA_W), R0..R7.
- T0: run=1 → IR←field, go T1; run=0 → stay T0, nothing changes.
- T1: mv/mvi → write Rx, done←1, go T0. NOP/reserved → done←1, no write, go T0. mvnz → write Rx←Ry only if zero=0, done←1, go T0. ALU ops → A←Rx, go T2.
- T2: G←A op Ry, go T3.
- T3: Rx←G, done←1, go T0.
- Every register write also loads outputProcessor with the written value; no write → outputProcessor holds.
- Arithmetic modulo 2^DATA_W. add: carry = bit DATA_W of zero-extended sum. sub: carry = 1 iff A < Ry unsigned (borrow). and/or: carry cleared.
- zero/carry update only at the T2 edge of ALU ops; mv/mvi/NOP leave them unchanged.
- Rx = Ry allowed (add R3,R3 doubles R3).
- run asserted while not in T0: ignored, no queuing.

## Timing
- Reset (async assert, sync release): step=T0, IR=0, A=0, G=0, R0..R7=0, done=0, outputProcessor=0, zero=0, carry=0. Reset mid-instruction aborts it; no partial write survives.
- Latency from the edge that latches IR (edge k): mv/mvi/NOP/mvnz write and raise done at edge k+1; ALU ops at edge k+3.
- done high exactly one cycle; cleared at the next edge.
- Back-to-back: run held high → next IR latched on the edge where done is high, i.e. throughput 2 or 4 cycles per instruction.
- mvi immediate must be valid on iin in the cycle the core is in T1.

## Configuration
- PROC_FLAGS_EN defined: zero and carry ports and flag registers exist; opcode 110 is mvnz.
- Undefined: no zero/carry ports or flag logic; opcode 110 behaves as NOP (done pulse after 1 step, no write).

## Test plan
- Reset then mvi R0,#5 (DATA_W=16): iin=0x2000 with run, then iin=0x0005 → R0=5, outputProcessor=0x0005, done pulse at edge k+1.
- mvi R1,#3; add R0,R1 → outputProcessor=0x0008 at edge k+3, done single-cycle, zero=0, carry=0.
- R0=0x0003, R1=0x0005, sub R0,R1 → R0=0xFFFE, carry=1; then mvi R2,#0, mvnz R3,R2 → R3 written, since zero=0.
- R0=0xFFFF, R1=0x0001, add → R0=0x0000, zero=1, carry=1; following mvnz → no write, outputProcessor holds 0x0000, done still pulses.
- resetn low during T2 of an add → all registers and outputs 0, step T0; after release with run=0 core stays idle, done stays 0.
- DATA_W=9 build, run held high across mv,R1,R0 then NOP 111 → two done pulses 2 cycles apart; without PROC_FLAGS_EN opcode 110 completes as NOP.
